pixel_loader: RTL and testbench



---
 rtl/pixel_loader.sv | 144 ++++++++++++++
 tb/tb_pixel_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pixel_loader.sv
// pixel_loader: sprite compositor between eight sprite memories and the video path.
// A shared 48-bit read bus is time-multiplexed across eight banks, one slot per cycle.
// Each word period is eight cycles, and every memory word carries two adjacent pixels.
// The enabled sprites are merged by fixed priority: sprite 0 is the top layer.
// Two composed pixels leave on RGB every word period, each held for four cycles.
//
// Optional build macro TRANSPARENCY_EN:
//   defined   - a pixel equal to KEY_COLOR is transparent and never claims its position.
//   undefined - every pixel from an enabled sprite is opaque; KEY_COLOR is unused.
module pixel_loader #(
  parameter logic [23:0] BG_COLOR  = 24'h000000,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [47:0] DATA_IN,
  input  logic [7:0]  SPRITES_EN,
  output logic        MEM_CLK,
  output logic [15:0] MEM_ADDR,
  output logic [2:0]  MEM_SEL,
  output logic [23:0] RGB
);

  localparam logic [2:0] LAST_SLOT = 3'd7;
  localparam logic [2:0] HALF_SLOT = 3'd3;

  // Slot counter and shared word address
  logic [2:0]  slot;
  logic [15:0] word_addr;

  // Per-pixel claim flags and accumulators for the word being assembled
  logic        claim_a;
  logic        claim_b;
  logic [23:0] acc_a;
  logic [23:0] acc_b;

  // Output register and the parked second pixel of the previous word
  logic [23:0] rgb_q;
  logic [23:0] hold_b;

  // Combinational view of the word returned for the slot that ends on this edge
  logic [23:0] pix_a;
  logic [23:0] pix_b;
  logic        slot_en;
  logic        opaque_a;
  logic        opaque_b;
  logic        take_a;
  logic        take_b;
  logic        next_claim_a;
  logic        next_claim_b;
  logic [23:0] next_acc_a;
  logic [23:0] next_acc_b;
  logic [23:0] composed_a;
  logic [23:0] composed_b;
  logic        last_slot;
  logic        half_slot;

  // Memories are clocked on the opposite edge so read data is ready at the next CLK rise
  assign MEM_CLK  = ~CLK;
  assign MEM_SEL  = slot;
  assign MEM_ADDR = word_addr;
  assign RGB      = rgb_q;

`ifdef TRANSPARENCY_EN
  // Key-coloured pixels are holes that let lower layers show through
  always_comb begin
    opaque_a = (pix_a != KEY_COLOR);
    opaque_b = (pix_b != KEY_COLOR);
  end
`else
  logic key_color_unused;
  assign key_color_unused = ^KEY_COLOR;

  // Without colour keying every enabled pixel is solid
  always_comb begin
    opaque_a = 1'b1;
    opaque_b = 1'b1;
  end
`endif

  // Decide which halves of the incoming word claim a pixel and what the word composes to
  always_comb begin
    pix_a        = DATA_IN[47:24];
    pix_b        = DATA_IN[23:0];
    slot_en      = SPRITES_EN[slot];
    last_slot    = (slot == LAST_SLOT);
    half_slot    = (slot == HALF_SLOT);
    take_a       = slot_en && !claim_a && opaque_a;
    take_b       = slot_en && !claim_b && opaque_b;
    next_claim_a = claim_a | take_a;
    next_claim_b = claim_b | take_b;
    next_acc_a   = take_a ? pix_a : acc_a;
    next_acc_b   = take_b ? pix_b : acc_b;
    composed_a   = next_claim_a ? next_acc_a : BG_COLOR;
    composed_b   = next_claim_b ? next_acc_b : BG_COLOR;
  end

  // Walk the eight banks every word period and step the address at the end of each word
  always_ff @(posedge CLK) begin
    if (RESET) begin
      slot      <= 3'd0;
      word_addr <= 16'd0;
    end else begin
      slot <= slot + 3'd1;
      if (last_slot) begin
        word_addr <= word_addr + 16'd1;
      end
    end
  end

  // Accumulate the highest-priority opaque pixel per half, starting clean for every word
  always_ff @(posedge CLK) begin
    if (RESET) begin
      claim_a <= 1'b0;
      claim_b <= 1'b0;
      acc_a   <= 24'd0;
      acc_b   <= 24'd0;
    end else if (last_slot) begin
      claim_a <= 1'b0;
      claim_b <= 1'b0;
      acc_a   <= 24'd0;
      acc_b   <= 24'd0;
    end else begin
      claim_a <= next_claim_a;
      claim_b <= next_claim_b;
      acc_a   <= next_acc_a;
      acc_b   <= next_acc_b;
    end
  end

  // Present pixel A at the end of a word and pixel B half a word later
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rgb_q  <= 24'd0;
      hold_b <= 24'd0;
    end else if (last_slot) begin
      rgb_q  <= composed_a;
      hold_b <= composed_b;
    end else if (half_slot) begin
      rgb_q  <= hold_b;
    end
  end

endmodule

// File: tb/tb_pixel_loader.sv
// tb_pixel_loader: scoreboard bench for pixel_loader.
// A behavioural memory answers on MEM_CLK, and each word's expected pixels are queued
// when its enables are driven. The pixels are then popped as RGB updates.
module tb_pixel_loader;

  localparam logic [23:0] BG  = 24'h000000;
  localparam logic [23:0] KEY = 24'hFF00FF;

  logic        CLK;
  logic        RESET;
  logic [47:0] DATA_IN;
  logic [7:0]  SPRITES_EN;
  logic        MEM_CLK;
  logic [15:0] MEM_ADDR;
  logic [2:0]  MEM_SEL;
  logic [23:0] RGB;

  int          checks;
  int          passed;
  int          edge_cnt;
  int          mode;
  logic [23:0] sb_queue[$];
  logic [23:0] cur_rgb;

  pixel_loader #(.BG_COLOR(BG), .KEY_COLOR(KEY)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .DATA_IN    (DATA_IN),
    .SPRITES_EN (SPRITES_EN),
    .MEM_CLK    (MEM_CLK),
    .MEM_ADDR   (MEM_ADDR),
    .MEM_SEL    (MEM_SEL),
    .RGB        (RGB)
  );

  // 10-time-unit system clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Contents of bank sel at word addr for the current memory image
  function automatic logic [47:0] mem_word(input int m, input logic [2:0] sel, input logic [15:0] addr);
    logic [23:0] pat;
    logic [23:0] a;
    logic [23:0] b;
    pat = {8'hA0 | {5'd0, sel}, addr};
    a   = pat;
    b   = pat;
    if (m == 1) begin
      if (sel == 3'd0) begin
        a = KEY;
        b = 24'h112233;
      end else if (sel == 3'd1) begin
        a = 24'h445566;
        b = 24'h445566;
      end
    end else if (m == 2) begin
      a = {8'hB0 | {5'd0, sel}, addr};
      b = {8'hC0 | {5'd0, sel}, addr};
      if (sel[0] == addr[0]) a = KEY;
      if (sel == 3'd2) b = KEY;
    end
    return {a, b};
  endfunction

  // Reference composition: scan sprites top-down and take the first enabled solid pixel
  function automatic logic [23:0] ref_pixel(input int m, input logic [7:0] en_lo, input logic [7:0] en_hi,
                                            input logic [15:0] addr, input bit half_b);
    logic [47:0] w;
    logic [23:0] p;
    logic        en;
    logic        solid;
    for (int i = 0; i < 8; i++) begin
      en = (i < 4) ? en_lo[i] : en_hi[i];
      w  = mem_word(m, 3'(i), addr);
      p  = half_b ? w[23:0] : w[47:24];
`ifdef TRANSPARENCY_EN
      solid = (p != KEY);
`else
      solid = 1'b1;
`endif
      if (en && solid) return p;
    end
    return BG;
  endfunction

  // Synchronous-read sprite memory clocked by MEM_CLK
  always @(posedge MEM_CLK) begin
    DATA_IN <= mem_word(mode, MEM_SEL, MEM_ADDR);
  end

  // Count one comparison and report it when the observed value differs
  task automatic checkOutput(input string tag, input logic [47:0] actual, input logic [47:0] expected);
    checks++;
    if (actual === expected) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, actual, expected, edge_cnt);
    end
  endtask

  // Advance one clock and check sequencing and pixel output just after the edge
  task automatic tick();
    logic [23:0] exp_px;
    @(posedge CLK);
    #1;
    checkOutput("mem_clk", 48'(MEM_CLK), 48'(1'b0));
    if (RESET) begin
      edge_cnt = 0;
      cur_rgb  = BG;
      checkOutput("rst_sel", 48'(MEM_SEL), 48'd0);
      checkOutput("rst_addr", 48'(MEM_ADDR), 48'd0);
      checkOutput("rst_rgb", 48'(RGB), 48'(BG));
    end else begin
      edge_cnt++;
      checkOutput("sel", 48'(MEM_SEL), 48'(edge_cnt % 8));
      checkOutput("addr", 48'(MEM_ADDR), 48'((edge_cnt / 8) % 65536));
      if (edge_cnt >= 8 && edge_cnt % 4 == 0) begin
        if (sb_queue.size() == 0) begin
          checks++;
          $display("[TB] FAIL rgb_pop: got %0h, expected nothing queued (edge %0d)", RGB, edge_cnt);
        end else begin
          exp_px  = sb_queue.pop_front();
          cur_rgb = exp_px;
          checkOutput("rgb", 48'(RGB), 48'(exp_px));
        end
      end else begin
        checkOutput("rgb_hold", 48'(RGB), 48'(cur_rgb));
      end
    end
  endtask

  // Drive one word period: en_lo covers slots 0..3, en_hi slots 4..7
  task automatic applyStimulus(input int m, input logic [7:0] en_lo, input logic [7:0] en_hi);
    logic [15:0] addr;
    addr = 16'((edge_cnt / 8) % 65536);
    mode = m;
    sb_queue.push_back(ref_pixel(m, en_lo, en_hi, addr, 1'b0));
    sb_queue.push_back(ref_pixel(m, en_lo, en_hi, addr, 1'b1));
    SPRITES_EN = en_lo;
    repeat (4) tick();
    SPRITES_EN = en_hi;
    repeat (4) tick();
  endtask

  initial begin
    logic [7:0] r_lo;
    logic [7:0] r_hi;
    checks     = 0;
    passed     = 0;
    edge_cnt   = 0;
    mode       = 0;
    cur_rgb    = BG;
    DATA_IN    = 48'd0;
    SPRITES_EN = 8'h00;
    RESET      = 1'b1;
    tick();
    RESET = 1'b0;

    $display("[TB] single sprite, priority, disable, all enabled");
    applyStimulus(0, 8'h01, 8'h01);
    applyStimulus(0, 8'h01, 8'h01);
    applyStimulus(0, 8'h0C, 8'h0C);
    applyStimulus(0, 8'h00, 8'h00);
    applyStimulus(0, 8'hFF, 8'hFF);
    applyStimulus(0, 8'hF0, 8'hF0);

    $display("[TB] colour key image");
    applyStimulus(1, 8'h03, 8'h03);
    applyStimulus(1, 8'h02, 8'h02);

    $display("[TB] mixed images with mid-word enable changes");
    applyStimulus(2, 8'h00, 8'h10);
    applyStimulus(2, 8'h05, 8'hFA);
    for (int k = 0; k < 6; k++) begin
      r_lo = 8'($urandom_range(0, 255));
      r_hi = 8'($urandom_range(0, 255));
      applyStimulus(2, r_lo, r_hi);
    end

    $display("[TB] reset in the middle of a word");
    mode       = 0;
    SPRITES_EN = 8'h00;
    repeat (4) tick();
    RESET = 1'b1;
    tick();
    sb_queue.delete();
    RESET = 1'b0;
    applyStimulus(0, 8'h01, 8'h01);
    applyStimulus(0, 8'h0C, 8'h0C);
    SPRITES_EN = 8'h00;
    repeat (4) tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
